// File: rtl/row_allocator.sv
// ---------------------------------------------------------------------------
// row_allocator
//
// Purpose:
//   Downstream stage of the row finder. It accepts one program width and up
//   to three candidate row IDs, and checks the candidates in priority order
//   (one per cycle) against per-row occupancy. The first row with enough
//   free columns is committed. The block returns the granted row and its
//   start column. It keeps the running fill level of every placement row.
//
// Ports:
//   clk        in   1  clock, all state changes on posedge
//   rst_n      in   1  asynchronous, active-low reset
//   req_valid  in   1  request present
//   req_ready  out  1  block can accept a request (IDLE and no clr)
//   width_in   in   5  program width in columns
//   str_id_1   in   4  candidate row, highest priority (0 = none)
//   str_id_2   in   4  candidate row, second priority (0 = none)
//   str_id_3   in   4  candidate row, third priority (0 = none)
//   out_valid  out  1  result present, held until out_ready
//   out_ready  in   1  consumer accepts result
//   out_ok     out  1  1 = placed, 0 = no candidate fits
//   out_row    out  4  granted row ID (0 when out_ok=0)
//   out_col    out  5  start column in granted row (0 when out_ok=0)
//   clr        in   1  synchronous clear of all row occupancy
//   fail_cnt   out  8  saturating count of failed requests
//
// Configuration macro:
//   ROW_ALLOC_STATS_EN  when defined, fail_cnt counts failed requests
//                       (saturating at 255, cleared by rst_n only).
//                       When undefined, fail_cnt is tied to 0.
// ---------------------------------------------------------------------------
module row_allocator #(
  parameter int NUM_ROWS  = 13,
  parameter int ROW_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] width_in,
  input  logic [3:0] str_id_1,
  input  logic [3:0] str_id_2,
  input  logic [3:0] str_id_3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_ok,
  output logic [3:0] out_row,
  output logic [4:0] out_col,
  input  logic       clr,
  output logic [7:0] fail_cnt
);

  localparam logic [3:0] MAX_ID = 4'(NUM_ROWS);
  localparam logic [5:0] ROW_W6 = 6'(ROW_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CHK  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [4:0] width_reg;
  logic [3:0] cand1_reg, cand2_reg, cand3_reg;
  logic [1:0] idx_reg;
  logic       out_ok_reg;
  logic [3:0] out_row_reg;
  logic [4:0] out_col_reg;

  // Occupancy (next free column) of each placement row.
  logic [4:0] used_reg [1:NUM_ROWS];
  logic [NUM_ROWS:1][4:0] used_next;

  logic [3:0] cand_id;
  logic [4:0] used_sel;
  logic [5:0] sum;
  logic       fit;
  logic       accept;
  logic       commit;
  logic       last_cand;

  assign req_ready = (state_reg == IDLE) && !clr;
  assign out_valid = (state_reg == RESP);
  assign accept    = req_valid && req_ready;
  assign last_cand = (idx_reg == 2'd2);
  assign commit    = (state_reg == CHK) && fit;

  assign out_ok  = out_ok_reg;
  assign out_row = out_row_reg;
  assign out_col = out_col_reg;

  // Candidate under evaluation this cycle.
  always_comb begin
    cand_id = cand1_reg;
    case (idx_reg)
      2'd1:    cand_id = cand2_reg;
      2'd2:    cand_id = cand3_reg;
      default: cand_id = cand1_reg;
    endcase
  end

  // Occupancy lookup; out-of-range IDs read as 0 and are rejected by fit.
  always_comb begin
    used_sel = '0;
    for (int r = 1; r <= NUM_ROWS; r++) begin
      if (cand_id == 4'(r)) begin
        used_sel = used_reg[r];
      end
    end
  end

  // The sum is 6 bits wide so a 31-column width on a partly used row
  // cannot wrap around and look like a fit.
  assign sum = {1'b0, used_sel} + {1'b0, width_reg};
  assign fit = (cand_id != 4'd0) && (cand_id <= MAX_ID) &&
               (width_reg != 5'd0) && (sum <= ROW_W6);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = CHK;
      CHK:  if (fit || last_cand) state_next = RESP;
      RESP: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, candidate index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_reg   <= '0;
      cand1_reg   <= '0;
      cand2_reg   <= '0;
      cand3_reg   <= '0;
      idx_reg     <= '0;
      out_ok_reg  <= 1'b0;
      out_row_reg <= '0;
      out_col_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            width_reg <= width_in;
            cand1_reg <= str_id_1;
            cand2_reg <= str_id_2;
            cand3_reg <= str_id_3;
            idx_reg   <= 2'd0;
          end
        end
        CHK: begin
          if (fit) begin
            out_ok_reg  <= 1'b1;
            out_row_reg <= cand_id;
            out_col_reg <= used_sel;
          end else if (last_cand) begin
            out_ok_reg  <= 1'b0;
            out_row_reg <= '0;
            out_col_reg <= '0;
          end else begin
            idx_reg <= idx_reg + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-row next occupancy. clr has priority over a same-cycle commit; the
  // response still carries the out_col computed before the clear.
  genvar gi;
  generate
    for (gi = 1; gi <= NUM_ROWS; gi++) begin : g_row
      assign used_next[gi] = clr ? 5'd0 :
                             (commit && (cand_id == 4'(gi))) ? sum[4:0] :
                             used_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r <= NUM_ROWS; r++) begin
        used_reg[r] <= '0;
      end
    end else begin
      for (int r = 1; r <= NUM_ROWS; r++) begin
        used_reg[r] <= used_next[r];
      end
    end
  end

`ifdef ROW_ALLOC_STATS_EN
  logic [7:0] fail_cnt_reg;

  // Counts CHK->RESP transitions that carry out_ok=0; not affected by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt_reg <= '0;
    end else if ((state_reg == CHK) && !fit && last_cand &&
                 (fail_cnt_reg != 8'hFF)) begin
      fail_cnt_reg <= fail_cnt_reg + 8'd1;
    end
  end

  assign fail_cnt = fail_cnt_reg;
`else
  assign fail_cnt = '0;
`endif

endmodule
